axi_ooo_mem_slave: RTL and testbench

Synthesizable, parametrised AXI-lite memory slave with multi-ID out-of-order read responses. It sits at the end of the master→monitor→slave chain as a drop-in replacement for the behavioural slave model. Per-ID read queues are drained by a round-robin arbiter, and all five channels use real full/empty backpressure. Writes and reads to out-of-range words are rejected with SLVERR.

---
 rtl/axi_ooo_mem_slave_pkg.sv | 23 ++
 rtl/axi_ooo_mem_slave_fifo.sv | 64 ++++++
 rtl/axi_ooo_mem_slave.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_ooo_mem_slave.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ooo_mem_slave_pkg.sv
// Shared AXI transaction package: default widths, bus types and response codes
// used by the out-of-order memory slave and its read/write queues.
package axi_transaction;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int n_ids      = 4;
    localparam int AXI_ID_W   = 2;

    typedef logic [AXI_ADDR_W-1:0] addr_t;
    typedef logic [AXI_DATA_W-1:0] data_t;
    typedef logic [AXI_ID_W-1:0]   id_t;
    typedef logic [1:0]            resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    // ID field width for a given number of IDs; never narrower than one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_ooo_mem_slave_fifo.sv
// Synchronous FIFO with registered storage. A push is accepted while full
// when a pop happens in the same cycle, so a full queue keeps streaming.
module axi_sync_fifo
    import axi_transaction::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer advance with wrap at DEPTH-1 so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count_r == '0);
    assign full      = (count_r == CNT_W'(DEPTH));
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign dout      = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Entry storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/axi_ooo_mem_slave.sv
// AXI-lite memory slave with per-ID read queues drained out of order by a
// round-robin arbiter. Out-of-range words answer SLVERR.
// Optional feature macro: AXI_OOO_SLAVE_WRITTEN_CHECK_EN -- tracks a written
// bit per word and answers SLVERR with zero data for never-written words.
module axi_ooo_mem_slave
    import axi_transaction::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int N_IDS     = 4,
    parameter int MEM_WORDS = 256,
    parameter int RD_DEPTH  = 4,
    parameter int WR_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           araddr,
    input  logic [id_width(N_IDS)-1:0]  arid,
    input  logic                        arvalid,
    output logic                        arready,
    input  logic [ADDR_W-1:0]           awaddr,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [DATA_W-1:0]           wdata,
    input  logic                        wvalid,
    output logic                        wready,
    output logic [DATA_W-1:0]           rdata,
    output logic [id_width(N_IDS)-1:0]  rid,
    output logic [1:0]                  rresp,
    output logic                        rvalid,
    input  logic                        rready,
    output logic [1:0]                  bresp,
    output logic                        bvalid,
    input  logic                        bready
);

    localparam int ID_W   = id_width(N_IDS);
    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int WORD_W = ADDR_W - OFF_W;
    localparam int MIDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int RQ_W   = DATA_W + 2;

    // Storage and ready gating
    logic [DATA_W-1:0] mem_r [MEM_WORDS];
    logic              ready_en_r;
    logic              unused_s;

    // Write path
    logic              aw_full_s, aw_empty_s, w_full_s, w_empty_s, b_full_s, b_empty_s;
    logic [ADDR_W-1:0] aw_dout_s;
    logic [DATA_W-1:0] w_dout_s;
    logic [1:0]        b_din_s, b_dout_s;
    logic              commit_s;
    logic [WORD_W-1:0] aw_word_s;
    logic [MIDX_W-1:0] aw_midx_s;
    logic              aw_in_range_s;
    logic              b_pop_s;

    // Read path
    logic              ar_hs_s;
    logic [WORD_W-1:0] ar_word_s;
    logic [MIDX_W-1:0] ar_midx_s;
    logic              ar_in_range_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [1:0]        rd_resp_s;
    logic [RQ_W-1:0]   rq_din_s;
    logic [RQ_W-1:0]   rq_dout_s [N_IDS];
    logic [N_IDS-1:0]  rq_push_s, rq_pop_s, rq_full_s, rq_empty_s;
    logic [ID_W-1:0]   r_last_r;
    logic [ID_W-1:0]   r_sel_s;
    logic              r_found_s;
    logic              r_adv_s;
    logic              r_take_s;

    // Byte-offset bits carry no meaning for word-wide storage
    assign unused_s = ^{araddr, aw_dout_s};

    assign arready = ready_en_r & ~(|rq_full_s);
    assign awready = ready_en_r & ~aw_full_s;
    assign wready  = ready_en_r & ~w_full_s;

    // Ready outputs stay low in reset and open on the first edge afterwards
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // ---------------- write channel ----------------
    axi_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(WR_DEPTH)) u_aw_q (
        .clk(clk), .rst_n(rst), .push(awvalid & awready), .din(awaddr),
        .pop(commit_s), .dout(aw_dout_s), .full(aw_full_s), .empty(aw_empty_s)
    );

    axi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(WR_DEPTH)) u_w_q (
        .clk(clk), .rst_n(rst), .push(wvalid & wready), .din(wdata),
        .pop(commit_s), .dout(w_dout_s), .full(w_full_s), .empty(w_empty_s)
    );

    axi_sync_fifo #(.WIDTH(2), .DEPTH(WR_DEPTH)) u_b_q (
        .clk(clk), .rst_n(rst), .push(commit_s), .din(b_din_s),
        .pop(b_pop_s), .dout(b_dout_s), .full(b_full_s), .empty(b_empty_s)
    );

    assign commit_s      = ~aw_empty_s & ~w_empty_s & ~b_full_s;
    assign aw_word_s     = aw_dout_s[ADDR_W-1:OFF_W];
    assign aw_midx_s     = aw_word_s[MIDX_W-1:0];
    assign aw_in_range_s = (aw_word_s < WORD_W'(MEM_WORDS));
    assign b_din_s       = aw_in_range_s ? RESP_OKAY : RESP_SLVERR;

    // Memory write on an in-range commit; contents survive reset
    always_ff @(posedge clk) begin
        if (commit_s & aw_in_range_s) begin
            mem_r[aw_midx_s] <= w_dout_s;
        end
    end

    assign b_pop_s = (~bvalid | bready) & ~b_empty_s;

    // B output register: refill from the B queue whenever the slot is free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bvalid <= 1'b0;
            bresp  <= 2'b00;
        end else if (~bvalid | bready) begin
            bvalid <= ~b_empty_s;
            if (~b_empty_s) begin
                bresp <= b_dout_s;
            end
        end
    end

    // ---------------- read channel ----------------
    assign ar_hs_s       = arvalid & arready;
    assign ar_word_s     = araddr[ADDR_W-1:OFF_W];
    assign ar_midx_s     = ar_word_s[MIDX_W-1:0];
    assign ar_in_range_s = (ar_word_s < WORD_W'(MEM_WORDS));

`ifdef AXI_OOO_SLAVE_WRITTEN_CHECK_EN
    logic [MEM_WORDS-1:0] written_r;

    // Mark words that have seen an in-range commit since reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            written_r <= '0;
        end else if (commit_s & aw_in_range_s) begin
            written_r[aw_midx_s] <= 1'b1;
        end
    end

    // Read lookup: out-of-range or never-written words answer SLVERR with zero data
    always_comb begin
        rd_data_s = '0;
        rd_resp_s = RESP_SLVERR;
        if (ar_in_range_s && written_r[ar_midx_s]) begin
            rd_data_s = mem_r[ar_midx_s];
            rd_resp_s = RESP_OKAY;
        end else begin
            rd_data_s = '0;
            rd_resp_s = RESP_SLVERR;
        end
    end
`else
    // Read lookup: out-of-range words answer SLVERR with zero data
    always_comb begin
        rd_data_s = '0;
        rd_resp_s = RESP_SLVERR;
        if (ar_in_range_s) begin
            rd_data_s = mem_r[ar_midx_s];
            rd_resp_s = RESP_OKAY;
        end else begin
            rd_data_s = '0;
            rd_resp_s = RESP_SLVERR;
        end
    end
`endif

    assign rq_din_s = {rd_data_s, rd_resp_s};

    for (genvar g = 0; g < N_IDS; g++) begin : g_rq
        assign rq_push_s[g] = ar_hs_s & (arid == ID_W'(g));
        assign rq_pop_s[g]  = r_take_s & (r_sel_s == ID_W'(g));

        axi_sync_fifo #(.WIDTH(RQ_W), .DEPTH(RD_DEPTH)) u_rq (
            .clk(clk), .rst_n(rst), .push(rq_push_s[g]), .din(rq_din_s),
            .pop(rq_pop_s[g]), .dout(rq_dout_s[g]), .full(rq_full_s[g]),
            .empty(rq_empty_s[g])
        );
    end

    // Round-robin pick: first non-empty queue after the last granted ID
    always_comb begin
        logic [ID_W-1:0] cand_v;
        logic            hit_v;
        r_sel_s   = r_last_r;
        r_found_s = 1'b0;
        cand_v    = '0;
        hit_v     = 1'b0;
        for (int k = 1; k <= N_IDS; k++) begin
            cand_v    = ID_W'((int'(r_last_r) + k) % N_IDS);
            hit_v     = ~r_found_s & ~rq_empty_s[cand_v];
            r_sel_s   = hit_v ? cand_v : r_sel_s;
            r_found_s = r_found_s | hit_v;
        end
    end

    assign r_adv_s  = ~rvalid | rready;
    assign r_take_s = r_adv_s & r_found_s;

    // R output register and arbiter pointer; held while the master stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid   <= 1'b0;
            rdata    <= '0;
            rid      <= '0;
            rresp    <= 2'b00;
            r_last_r <= ID_W'(N_IDS - 1);
        end else if (r_adv_s) begin
            rvalid <= r_found_s;
            if (r_found_s) begin
                rdata    <= rq_dout_s[r_sel_s][RQ_W-1:2];
                rresp    <= rq_dout_s[r_sel_s][1:0];
                rid      <= r_sel_s;
                r_last_r <= r_sel_s;
            end
        end
    end

endmodule

// File: tb/tb_axi_ooo_mem_slave.sv
// Scoreboard bench for axi_ooo_mem_slave: stimulus pushes expected responses,
// a negedge monitor pops and compares on every R/B handshake.
module tb_axi_ooo_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [1:0]  arid, rid, rresp, bresp;
    logic        arvalid, arready, awvalid, awready, wvalid, wready;
    logic        rvalid, rready, bvalid, bready;

    always #5 clk = ~clk;

    axi_ooo_mem_slave dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arid(arid), .arvalid(arvalid), .arready(arready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rid(rid), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        chk_data;
    } rexp_t;

    rexp_t      r_exp[$];
    logic [1:0] b_exp[$];
    logic [1:0] rid_log[$];
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         b_seen = 0;
    bit         wr_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("FAIL %s: actual=timeout required=completion", name);
    endtask

    task automatic exp_r(input logic [1:0] id, input logic [31:0] d, input logic [1:0] resp, input logic cd);
        rexp_t e;
        e.id = id; e.data = d; e.resp = resp; e.chk_data = cd;
        r_exp.push_back(e);
    endtask

    // Monitor: compare every completed R and B beat against the scoreboard
    always @(negedge clk) begin : mon
        int idx;
        if (rst && rvalid && rready) begin
            idx = -1;
            for (int i = 0; i < r_exp.size(); i++)
                if (idx < 0 && r_exp[i].id == rid) idx = i;
            if (idx < 0) begin
                total_cnt++;
                $display("FAIL r_unexpected: actual rid=%0d rdata=%0h required no response", rid, rdata);
            end else begin
                if (r_exp[idx].chk_data) chk("rdata", {32'h0, rdata}, {32'h0, r_exp[idx].data});
                chk("rresp", {62'h0, rresp}, {62'h0, r_exp[idx].resp});
                r_exp.delete(idx);
            end
            rid_log.push_back(rid);
        end
        if (rst && bvalid && bready) begin
            b_seen++;
            if (b_exp.size() == 0) begin
                total_cnt++;
                $display("FAIL b_unexpected: actual bresp=%0d required no response", bresp);
            end else begin
                chk("bresp", {62'h0, bresp}, {62'h0, b_exp.pop_front()});
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic aw_go, w_go;
        int   n;
        @(posedge clk); #1;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; n = 0;
        while ((awvalid || wvalid) && n < 200) begin
            @(negedge clk);
            aw_go = awvalid & awready;
            w_go  = wvalid & wready;
            @(posedge clk); #1;
            if (aw_go) awvalid = 1'b0;
            if (w_go) wvalid = 1'b0;
            n++;
        end
        if (awvalid || wvalid) begin
            fail_now("write_handshake");
            awvalid = 1'b0; wvalid = 1'b0;
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] id);
        logic go;
        int   n;
        @(posedge clk); #1;
        araddr = a; arid = id; arvalid = 1'b1; n = 0;
        while (arvalid && n < 200) begin
            @(negedge clk);
            go = arready;
            @(posedge clk); #1;
            if (go) arvalid = 1'b0;
            n++;
        end
        if (arvalid) begin
            fail_now("read_handshake");
            arvalid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((r_exp.size() != 0 || b_exp.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (r_exp.size() != 0 || b_exp.size() != 0) begin
            fail_now(name);
            r_exp.delete();
            b_exp.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bit saw_aw_low, saw_w_low;
        int b0, n;
        rst = 1'b0; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        araddr = '0; awaddr = '0; wdata = '0; arid = '0;
        rready = 1'b0; bready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", {63'h0, rvalid}, 64'h0);
        chk("rst_bvalid", {63'h0, bvalid}, 64'h0);
        chk("rst_rdata", {32'h0, rdata}, 64'h0);
        chk("rst_rid_rresp_bresp", {58'h0, rid, rresp, bresp}, 64'h0);
        chk("rst_readys", {61'h0, arready, awready, wready}, 64'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("readys_before_edge", {61'h0, arready, awready, wready}, 64'h0);
        @(negedge clk);
        chk("readys_after_edge", {61'h0, arready, awready, wready}, 64'h7);
        rready = 1'b1; bready = 1'b1;

        // Write then read, with minimum latencies
        b_exp.push_back(2'b00);
        wr(32'h10, 32'hDEADBEEF);
        @(negedge clk); chk("b_lat_n0", {63'h0, bvalid}, 64'h0);
        @(negedge clk); chk("b_lat_n1", {63'h0, bvalid}, 64'h0);
        @(negedge clk); chk("b_lat_n2", {63'h0, bvalid}, 64'h1);
        wait_idle("idle_wr1");
        exp_r(2'd1, 32'hDEADBEEF, 2'b00, 1'b1);
        rd(32'h10, 2'd1);
        @(negedge clk); chk("r_lat_n0", {63'h0, rvalid}, 64'h0);
        @(negedge clk); chk("r_lat_n1", {63'h0, rvalid}, 64'h1);
        chk("r_lat_rid", {62'h0, rid}, 64'h1);
        wait_idle("idle_rd1");

        // Out-of-range write/read and last in-range word (low byte bits ignored)
        b_exp.push_back(2'b10);
        wr(32'h400, 32'h12345678);
        wait_idle("idle_oor_wr");
        exp_r(2'd3, 32'h0, 2'b10, 1'b1);
        rd(32'h400, 2'd3);
        b_exp.push_back(2'b00);
        wr(32'h3FC, 32'hCAFEF00D);
        wait_idle("idle_last_wr");
        exp_r(2'd2, 32'hCAFEF00D, 2'b00, 1'b1);
        rd(32'h3FE, 2'd2);
        wait_idle("idle_last_rd");

        // Never-written word
`ifdef AXI_OOO_SLAVE_WRITTEN_CHECK_EN
        exp_r(2'd0, 32'h0, 2'b10, 1'b1);
`else
        exp_r(2'd0, 32'h0, 2'b00, 1'b0);
`endif
        rd(32'h20, 2'd0);
        wait_idle("idle_unwritten");

        // Round-robin reordering: ID0 x3, ID2 x1 while rready is low
        for (int i = 0; i < 4; i++) begin
            b_exp.push_back(2'b00);
            wr(32'h40 + 4 * i, 32'h1111_0000 * (i + 1));
        end
        wait_idle("idle_rr_fill");
        rready = 1'b0;
        rid_log.delete();
        exp_r(2'd0, 32'h1111_0000, 2'b00, 1'b1);
        exp_r(2'd0, 32'h2222_0000, 2'b00, 1'b1);
        exp_r(2'd0, 32'h3333_0000, 2'b00, 1'b1);
        exp_r(2'd2, 32'h4444_0000, 2'b00, 1'b1);
        rd(32'h40, 2'd0);
        rd(32'h44, 2'd0);
        rd(32'h48, 2'd0);
        rd(32'h4C, 2'd2);
        repeat (3) @(posedge clk);
        #1 rready = 1'b1;
        wait_idle("idle_rr");
        chk("rr_count", 64'(rid_log.size()), 64'h4);
        if (rid_log.size() == 4)
            chk("rr_order", {56'h0, rid_log[0], rid_log[1], rid_log[2], rid_log[3]}, {56'h0, 8'b00_10_00_00});

        // Backpressure: 10 writes with bready low
        bready = 1'b0;
        b0 = b_seen;
        wr_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    b_exp.push_back(2'b00);
                    wr(32'h80 + 4 * i, 32'hA5A5_0000 + i);
                end
                wr_done = 1'b1;
            end
        join_none
        saw_aw_low = 1'b0; saw_w_low = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (!awready) saw_aw_low = 1'b1;
            if (!wready) saw_w_low = 1'b1;
        end
        chk("bp_awready_low", {63'h0, saw_aw_low}, 64'h1);
        chk("bp_wready_low", {63'h0, saw_w_low}, 64'h1);
        chk("bp_no_b_yet", 64'(b_seen - b0), 64'h0);
        @(posedge clk); #1 bready = 1'b1;
        n = 0;
        while (!wr_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!wr_done) fail_now("bp_writer");
        wait_idle("idle_bp");
        chk("bp_b_count", 64'(b_seen - b0), 64'd10);
        for (int i = 0; i < 10; i++) begin
            exp_r(2'(i % 4), 32'hA5A5_0000 + i, 2'b00, 1'b1);
            rd(32'h80 + 4 * i, 2'(i % 4));
        end
        wait_idle("idle_bp_rd");

        // Reset with outstanding traffic
        rready = 1'b0; bready = 1'b0;
        wr(32'h100, 32'h0BAD_F00D);
        rd(32'h40, 2'd1);
        rd(32'h44, 2'd1);
        rd(32'h48, 2'd1);
        repeat (3) @(negedge clk);
        chk("pre_rst_valids", {62'h0, rvalid, bvalid}, 64'h3);
        rst = 1'b0;
        #1;
        chk("mid_rst_valids", {62'h0, rvalid, bvalid}, 64'h0);
        chk("mid_rst_readys", {61'h0, arready, awready, wready}, 64'h0);
        @(posedge clk); #1 rst = 1'b1;
        rready = 1'b1; bready = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_quiet", {62'h0, rvalid, bvalid}, 64'h0);
`ifdef AXI_OOO_SLAVE_WRITTEN_CHECK_EN
        exp_r(2'd2, 32'h0, 2'b10, 1'b1);
`else
        exp_r(2'd2, 32'hDEADBEEF, 2'b00, 1'b1);
`endif
        rd(32'h10, 2'd2);
        wait_idle("idle_post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
